// File: rtl/rvfi_mem_stall_pkg.sv
// Shared constants, types and seed/tap helpers for the RVFI memory stall generator.
// The optional forced-ready bound is compiled in with RVFI_MEM_STALL_FAIRNESS_EN.
package rvfi_mem_stall_pkg;

    localparam logic [63:0] TAPS_W8   = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] TAPS_W16  = 64'h0000_0000_0000_B400;
    localparam logic [63:0] TAPS_W32  = 64'h0000_0000_8020_0003;
    localparam logic [63:0] TAPS_W64  = 64'hD800_0000_0000_0000;
    localparam logic [63:0] SEED_MIX  = 64'h9E37_79B9_7F4A_7C15;

    typedef logic [7:0]  stall_cnt_t;
    typedef logic [15:0] hs_cnt_t;

    localparam stall_cnt_t STALL_CNT_MAX = 8'hFF;
    localparam hs_cnt_t    HS_CNT_MAX    = 16'hFFFF;

    typedef struct packed {
        hs_cnt_t    hs_cnt;
        stall_cnt_t run;
        stall_cnt_t stall_max;
    } chan_stats_t;

    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            8:       return TAPS_W8;
            16:      return TAPS_W16;
            32:      return TAPS_W32;
            default: return TAPS_W64;
        endcase
    endfunction

    function automatic logic [63:0] width_mask(input int width);
        if (width >= 64)
            return '1;
        return (64'd1 << width) - 64'd1;
    endfunction

    // Spread channel seeds with a golden-ratio constant; an all-zero LFSR would lock up.
    function automatic logic [63:0] chan_seed(input logic [63:0] seed, input int c, input int width);
        logic [63:0] s;
        s = (seed ^ (64'(c) * SEED_MIX)) & width_mask(width);
        if (s == 64'd0)
            s = 64'd1;
        return s;
    endfunction

endpackage

// File: rtl/rvfi_lfsr.sv
// Right-shifting Galois LFSR, advancing every cycle; reset loads SEED.
module rvfi_lfsr
    import rvfi_mem_stall_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // NOTE: combinational blocks assign a default first so no path leaves a variable unassigned (no latch).
    always_comb begin
        state_d = state_q >> 1;
        if (state_q[0])
            state_d = state_d ^ TAPS;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= SEED;
        else
            state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/rvfi_mem_stall_gen.sv
// Per-channel registered ready/rdata generator driven by LFSRs, with handshake statistics.
// Define RVFI_MEM_STALL_FAIRNESS_EN to force ready after MAX_WAIT consecutive stalls.
module rvfi_mem_stall_gen
    import rvfi_mem_stall_pkg::*;
#(
    parameter int          NCH          = 2,
    parameter int          DATA_W       = 32,
    parameter int          MAX_WAIT     = 3,
    parameter int          READY_THRESH = 8,
    parameter logic [63:0] SEED         = 64'hACE1_2468_1357_9BDF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NCH-1:0]        valid_i,
    output logic [NCH-1:0]        ready_o,
    output logic [NCH*DATA_W-1:0] rdata_o,
    output logic [NCH*16-1:0]     hs_cnt_o,
    output logic [NCH*8-1:0]      stall_max_o
);

    localparam logic [4:0] THRESH = 5'(READY_THRESH);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        logic [DATA_W-1:0] lfsr;
        logic              rnd;
        logic              stall;
        logic              handshake;
        logic              ready_d;
        logic              ready_q;
        chan_stats_t       stats_q;
        chan_stats_t       stats_d;

        rvfi_lfsr #(
            .WIDTH (DATA_W),
            .TAPS  (DATA_W'(lfsr_taps(DATA_W))),
            .SEED  (DATA_W'(chan_seed(SEED, c, DATA_W)))
        ) u_lfsr (
            .clock   (clock),
            .reset   (reset),
            .state_o (lfsr)
        );

        // Five-bit compare so READY_THRESH = 16 means always ready.
        assign rnd       = ({1'b0, lfsr[3:0]} < THRESH);
        assign stall     = valid_i[c] & ~ready_q;
        assign handshake = valid_i[c] &  ready_q;

`ifdef RVFI_MEM_STALL_FAIRNESS_EN
        localparam int                WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
        localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

        logic [WAIT_W-1:0] wait_q;
        logic [WAIT_W-1:0] wait_d;

        always_comb begin
            wait_d = '0;
            if (stall)
                wait_d = (wait_q >= WAIT_LIM) ? wait_q : wait_q + WAIT_W'(1);
        end

        assign ready_d = rnd | (wait_d >= WAIT_LIM);

        always_ff @(posedge clock or posedge reset) begin
            if (reset)
                wait_q <= '0;
            else
                wait_q <= wait_d;
        end
`else
        assign ready_d = rnd;
`endif

        always_comb begin
            stats_d = stats_q;
            if (handshake && (stats_q.hs_cnt != HS_CNT_MAX))
                stats_d.hs_cnt = stats_q.hs_cnt + 16'd1;
            if (stall)
                stats_d.run = (stats_q.run == STALL_CNT_MAX) ? stats_q.run : stats_q.run + 8'd1;
            else
                stats_d.run = '0;
            if (stats_d.run > stats_q.stall_max)
                stats_d.stall_max = stats_d.run;
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                ready_q <= 1'b0;
                stats_q <= '0;
            end else begin
                ready_q <= ready_d;
                stats_q <= stats_d;
            end
        end

        assign ready_o[c]                    = ready_q;
        assign rdata_o[c*DATA_W +: DATA_W]   = lfsr;
        assign hs_cnt_o[c*16 +: 16]          = stats_q.hs_cnt;
        assign stall_max_o[c*8 +: 8]         = stats_q.stall_max;
    end

endmodule

// File: tb/tb_rvfi_mem_stall_gen.sv
// Directed bench: three generator instances (default, always-stall, always-ready) on one clock/reset.
// Expectations for the always-stall instance follow RVFI_MEM_STALL_FAIRNESS_EN.
module tb_rvfi_mem_stall_gen;

    localparam logic [31:0] TAPS32  = 32'h8020_0003;
    localparam logic [31:0] SEED_C0 = 32'h1357_9BDF;
    localparam logic [31:0] SEED_C1 = 32'h6C1D_E7CA;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic [1:0]  valid_a = 2'b00;
    logic [1:0]  ready_a;
    logic [63:0] rdata_a;
    logic [31:0] hs_a;
    logic [15:0] smax_a;

    logic [0:0]  valid_z = 1'b1;
    logic [0:0]  ready_z;
    logic [31:0] rdata_z;
    logic [15:0] hs_z;
    logic [7:0]  smax_z;

    logic [1:0]  valid_f = 2'b11;
    logic [1:0]  ready_f;
    logic [63:0] rdata_f;
    logic [31:0] hs_f;
    logic [15:0] smax_f;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_state [2];
    logic        m_ready [2];

    always #5 clock = ~clock;

    rvfi_mem_stall_gen #(.NCH(2)) u_a (
        .clock(clock), .reset(reset), .valid_i(valid_a), .ready_o(ready_a),
        .rdata_o(rdata_a), .hs_cnt_o(hs_a), .stall_max_o(smax_a)
    );

    rvfi_mem_stall_gen #(.NCH(1), .MAX_WAIT(3), .READY_THRESH(0)) u_z (
        .clock(clock), .reset(reset), .valid_i(valid_z), .ready_o(ready_z),
        .rdata_o(rdata_z), .hs_cnt_o(hs_z), .stall_max_o(smax_z)
    );

    rvfi_mem_stall_gen #(.NCH(2), .READY_THRESH(16)) u_f (
        .clock(clock), .reset(reset), .valid_i(valid_f), .ready_o(ready_f),
        .rdata_o(rdata_f), .hs_cnt_o(hs_f), .stall_max_o(smax_f)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ TAPS32) : (s >> 1);
    endfunction

    // Always-stall instance: k = number of rising edges since reset release, valid held high.
    function automatic logic exp_z_ready(input int k);
`ifdef RVFI_MEM_STALL_FAIRNESS_EN
        return (k % 4) == 3;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] exp_z_hs(input int k);
`ifdef RVFI_MEM_STALL_FAIRNESS_EN
        return 16'(k / 4);
`else
        return 16'd0;
`endif
    endfunction

    function automatic logic [7:0] exp_z_smax(input int k);
`ifdef RVFI_MEM_STALL_FAIRNESS_EN
        return 8'((k < 3) ? k : 3);
`else
        return 8'((k < 255) ? k : 255);
`endif
    endfunction

    function automatic logic [15:0] exp_f_hs(input int k);
        if (k < 1)
            return 16'd0;
        return 16'(((k - 1) < 65535) ? (k - 1) : 65535);
    endfunction

    task automatic check_reset_values(input string pfx);
        check({pfx, "_ready_a"}, 64'(ready_a), 64'd0);
        check({pfx, "_rdata_a0"}, 64'(rdata_a[31:0]), 64'(SEED_C0));
        check({pfx, "_rdata_a1"}, 64'(rdata_a[63:32]), 64'(SEED_C1));
        check({pfx, "_hs_a"}, 64'(hs_a), 64'd0);
        check({pfx, "_smax_a"}, 64'(smax_a), 64'd0);
        check({pfx, "_ready_z"}, 64'(ready_z), 64'd0);
        check({pfx, "_smax_z"}, 64'(smax_z), 64'd0);
        check({pfx, "_hs_f"}, 64'(hs_f), 64'd0);
        check({pfx, "_ready_f"}, 64'(ready_f), 64'd0);
    endtask

    task automatic check_cycle(input int k);
        check("a_rdata0", 64'(rdata_a[31:0]), 64'(m_state[0]));
        check("a_rdata1", 64'(rdata_a[63:32]), 64'(m_state[1]));
        check("a_ready0", 64'(ready_a[0]), 64'(m_ready[0]));
        check("a_ready1", 64'(ready_a[1]), 64'(m_ready[1]));
        check("z_ready", 64'(ready_z[0]), 64'(exp_z_ready(k)));
        check("z_hs", 64'(hs_z), 64'(exp_z_hs(k)));
        check("z_smax", 64'(smax_z), 64'(exp_z_smax(k)));
        check("f_ready", 64'(ready_f), (k >= 1) ? 64'd3 : 64'd0);
        check("f_hs0", 64'(hs_f[15:0]), 64'(exp_f_hs(k)));
        check("f_hs1", 64'(hs_f[31:16]), 64'(exp_f_hs(k)));
        check("f_smax0", 64'(smax_f[7:0]), (k >= 1) ? 64'd1 : 64'd0);
        check("f_smax1", 64'(smax_f[15:8]), (k >= 1) ? 64'd1 : 64'd0);
    endtask

    // Called right after reset release (on a falling edge); checks n rising edges.
    task automatic run_window(input int n);
        logic [63:0] prev;
        m_state[0] = SEED_C0;
        m_state[1] = SEED_C1;
        m_ready[0] = 1'b0;
        m_ready[1] = 1'b0;
        check_cycle(0);
        for (int k = 1; k <= n; k++) begin
            prev = rdata_a;
            @(negedge clock);
            for (int c = 0; c < 2; c++) begin
                m_ready[c] = (m_state[c][3:0] < 4'd8);
                m_state[c] = lfsr_step(m_state[c]);
            end
            check("a_rdata_moves", 64'(rdata_a != prev), 64'd1);
            check_cycle(k);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_reset_values("rst");
        reset = 1'b0;
        run_window(18);

        // Mid-stall asynchronous reset: outputs must drop before the next rising edge.
        #2 reset = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge clock);
        check_reset_values("held_rst");
        reset = 1'b0;
        run_window(300);

        for (int k = 301; k <= 66000; k++) begin
            @(negedge clock);
            if (k == 65535 || k == 65536 || k == 65537 || k == 66000) begin
                check("long_f_hs0", 64'(hs_f[15:0]), 64'(exp_f_hs(k)));
                check("long_f_hs1", 64'(hs_f[31:16]), 64'(exp_f_hs(k)));
            end
        end
        check("long_f_hs_sat", 64'(hs_f), 64'hFFFF_FFFF);
        check("long_z_hs", 64'(hs_z), 64'(exp_z_hs(66000)));
        check("long_z_smax", 64'(smax_z), 64'(exp_z_smax(66000)));
        check("long_z_ready", 64'(ready_z[0]), 64'(exp_z_ready(66000)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rvfi_mem_stall_gen.md
# rvfi_mem_stall_gen

Parametrised, synthesizable memory-response generator for the RVFI harness. It drives `ready` and read data back to NCH independent valid/ready memory channels (instruction, data, further ports) from per-channel LFSRs instead of free formal random registers. A compile-time bounded-wait rule replaces the ad-hoc fairness restriction. It serves both simulation benches and formal runs with deterministic, reproducible stall patterns.

## Interface
- NCH, 2: number of memory channels
- DATA_W, 32: read-data and LFSR width; legal values 8, 16, 32, 64
- MAX_WAIT, 3: maximum consecutive stall cycles per channel when fairness is compiled in; 0 means ready is always high
- READY_THRESH, 8: ready probability in sixteenths, legal range 0..16
- SEED, 64'hACE1_2468_1357_9BDF: base LFSR seed

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- valid_i  in  NCH  per-channel request valid from the core
- ready_o  out  NCH  per-channel registered ready
- rdata_o  out  NCH*DATA_W  per-channel read data; channel c occupies bits [c*DATA_W +: DATA_W]
- hs_cnt_o  out  NCH*16  per-channel count of completed handshakes, saturating
- stall_max_o  out  NCH*8  per-channel longest stall run seen, saturating at 255

## Operation
- Handshake on channel c: `valid_i[c] && ready_o[c]` in the same cycle. The core samples `rdata_o[c]` in that cycle.
- LFSR:
  - One Galois LFSR per channel, DATA_W wide, advancing every cycle after reset.
  - Taps come from the package table.
  - Channel seed is `SEED[DATA_W-1:0] ^ (c * 64'h9E37_79B9_7F4A_7C15)`, truncated to DATA_W. A zero seed is replaced by 1.
- rdata_o[c] equals the current LFSR state.
- Random ready bit: `rnd[c] = (lfsr[c][3:0] < READY_THRESH)`.
- Stall counter `wait_q[c]`:
  - Width `$clog2(MAX_WAIT+1)`, saturating.
  - `wait_d = (valid_i && !ready_o) ? wait_q+1 : 0`.
- Next ready: `ready_d = rnd | (FAIRNESS && wait_d >= MAX_WAIT)`, registered into ready_o.
- Ready is independent of valid_i. Ready may be high with no request pending.
- hs_cnt_o[c] increments on each handshake and holds at 16'hFFFF.
- stall_max_o[c]:
  - A separate 8-bit run counter counts consecutive stall cycles.
  - stall_max updates to `max(stall_max, run)` every cycle.
  - The run counter clears on any non-stall cycle.
- Channels are fully independent. No arbitration, no shared state.

## Timing
- Reset values:
  - ready_o = 0
  - rdata_o[c] = seed of channel c
  - hs_cnt_o = 0, stall_max_o = 0
  - wait_q = 0, run counter = 0
- First cycle after reset deassertion: ready_o reflects `rnd` of the seed state.
- ready_o lags its inputs by exactly one cycle. The block never asserts ready combinationally.
- With fairness, a continuously valid request sees at most MAX_WAIT consecutive cycles of `ready_o=0`.
- valid_i dropping mid-stall clears wait_q on the next edge. The bound restarts for the next request.
- READY_THRESH = 0 with fairness gives exactly MAX_WAIT stalls then 1 ready per request. READY_THRESH = 16 keeps ready always high.
- Reset asserted mid-operation clears all state immediately and asynchronously. LFSRs reload their seeds.

## Configuration
- RVFI_MEM_STALL_FAIRNESS_EN defined: forced-ready bound active as above. stall_max_o never exceeds MAX_WAIT.
- Undefined: ready_o is purely `rnd`. A channel may stall indefinitely when READY_THRESH = 0. wait_q logic is removed; stall_max_o and hs_cnt_o are still built.

## Structure
- Package `rvfi_mem_stall_pkg`:
  - Galois tap constants for widths 8/16/32/64: 8'hB8, 16'hB400, 32'h8020_0003, 64'hD800_0000_0000_0000
  - function `chan_seed(c)`
  - typedef for the 8-bit stall counter
- Sub-module `rvfi_lfsr` (parameters WIDTH, TAPS, SEED; ports clock, reset, state_o), instantiated once per channel in a generate loop.
- Top holds the per-channel ready, wait, run and statistics registers.

## Test plan
- Reset with NCH=2, DATA_W=32: ready_o=2'b00, hs_cnt_o=0, rdata_o[0] = SEED low 32 bits, rdata_o[1] = that value ^ 32'h7F4A_7C15; release reset, and rdata_o changes every cycle.
- Fairness on, READY_THRESH=0, MAX_WAIT=3, valid_i[0] held high: ready_o[0] pattern is 0,0,0,1 repeating; stall_max_o[0]=3; hs_cnt_o[0] increments every 4th cycle.
- READY_THRESH=16, valid_i=2'b11 for 10 cycles after the first ready: hs_cnt_o = 10 on both channels; stall_max_o = 1 from the initial reset cycle.
- Fairness off, READY_THRESH=0, valid held high for 300 cycles: ready_o stays 0; stall_max_o saturates at 255; hs_cnt_o = 0.
- Assert reset for 1 cycle mid-stall (wait_q=2): all outputs return to reset values in the same cycle, and the LFSR sequence after release repeats the post-reset sequence bit-exactly.
- Hold hs_cnt_o near 16'hFFFF by forced long run (READY_THRESH=16, 70000 cycles): the counter holds at 16'hFFFF and does not wrap.
